fetch_stage: RTL and testbench

Instruction fetch stage for the five-stage pipelined RV32I core: owns the program counter and drives a valid/ready instruction-memory port with at most one outstanding request. It handles branch/jump redirects from Execute and feeds the IF/ID pipeline register that Decode consumes. A response that arrives while Decode is stalled is held in a one-entry skid buffer, so no fetched instruction is lost or duplicated.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid_buffer.sv | 44 ++++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  // ISSUE: request presented; WAIT: one request outstanding;
  // HOLD: skid buffer full while Decode stalls; DROP: discard the outstanding response
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding register for a response that Decode cannot take
module fetch_skid_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        unload_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pcplus4_q;
  logic        valid_q;

  // Capture on load; clear (redirect) wins over load so a squashed word never survives
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      instr_q   <= 32'h0;
      pc_q      <= 32'h0;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pc_q      <= pc_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end else if (unload_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, single-outstanding imem port, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  import fetch_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc_q;
  logic [31:0]  instr_d_q;
  logic [31:0]  pc_d_q;
  logic [31:0]  pcplus4_d_q;
  logic         valid_d_q;

  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_pcplus4;
  logic         skid_valid;

  logic         rsp_in_wait;
  logic         req_valid;
  logic         req_accept;
  logic         in_flight_after;

  // A response in WAIT lets the next request go out in the same cycle unless Decode stalls
  assign rsp_in_wait     = (state_q == WAIT) && ImemRspValid;
  assign req_valid       = !RST && ((state_q == ISSUE) || (rsp_in_wait && !StallD));
  assign req_accept      = req_valid && ImemReqReady;
  // After a redirect a response is still owed if one was just accepted or one is pending unanswered
  assign in_flight_after = req_accept ||
                           (((state_q == WAIT) || (state_q == DROP)) && !ImemRspValid);

  fetch_skid_buffer u_skid (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (rsp_in_wait && StallD && !PCSrcE),
    .clear_i   (PCSrcE),
    .unload_i  ((state_q == HOLD) && !StallD),
    .instr_i   (ImemRspData),
    .pc_i      (inflight_pc_q),
    .pcplus4_i (pc_plus4(inflight_pc_q)),
    .instr_o   (skid_instr),
    .pc_o      (skid_pc),
    .pcplus4_o (skid_pcplus4),
    .valid_o   (skid_valid)
  );

  // Fetch FSM with PC and in-flight address tracking; redirect overrides normal sequencing
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ISSUE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
    end else begin
      if (req_accept) begin
        inflight_pc_q <= pc_q;
      end
      if (PCSrcE) begin
        pc_q    <= align_pc(PCTargetE);
        state_q <= in_flight_after ? DROP : ISSUE;
      end else begin
        if (req_accept) begin
          pc_q <= pc_plus4(pc_q);
        end
        case (state_q)
          ISSUE: if (req_accept) state_q <= WAIT;
          WAIT: begin
            if (ImemRspValid) begin
              if (StallD)          state_q <= HOLD;
              else if (req_accept) state_q <= WAIT;
              else                 state_q <= ISSUE;
            end
          end
          HOLD: if (!StallD) state_q <= ISSUE;
          DROP: if (ImemRspValid) state_q <= ISSUE;
          default: state_q <= ISSUE;
        endcase
      end
    end
  end

  // IF/ID register: squash > stall hold > fresh response > skid unload > bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= 32'h0;
      pcplus4_d_q <= 32'h0;
      valid_d_q   <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      instr_d_q   <= NOP_INSTR;
      valid_d_q   <= 1'b0;
    end else if (StallD) begin
      valid_d_q   <= valid_d_q;
    end else if (rsp_in_wait) begin
      instr_d_q   <= ImemRspData;
      pc_d_q      <= inflight_pc_q;
      pcplus4_d_q <= pc_plus4(inflight_pc_q);
      valid_d_q   <= 1'b1;
    end else if (state_q == HOLD) begin
      instr_d_q   <= skid_instr;
      pc_d_q      <= skid_pc;
      pcplus4_d_q <= skid_pcplus4;
      valid_d_q   <= skid_valid;
    end else begin
      instr_d_q   <= NOP_INSTR;
      valid_d_q   <= 1'b0;
    end
  end

  assign ImemReqValid = req_valid;
  assign ImemReqAddr  = pc_q;
  assign InstrD       = instr_d_q;
  assign PCD          = pc_d_q;
  assign PCPlus4D     = pcplus4_d_q;
  assign ValidD       = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ImemReqValid;
  logic        ImemReqReady = 1'b0;
  logic [31:0] ImemReqAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = 32'h0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .ImemReqValid (ImemReqValid),
    .ImemReqReady (ImemReqReady),
    .ImemReqAddr  (ImemReqAddr),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D),
    .ValidD       (ValidD)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic rst, input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic stall, input logic flush, input logic pcsrc, input logic [31:0] tgt);
    @(negedge CLK);
    RST = rst; ImemReqReady = rdy; ImemRspValid = rspv; ImemRspData = rspd;
    StallD = stall; FlushD = flush; PCSrcE = pcsrc; PCTargetE = tgt;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b0) begin tests_failed++; $display("FAIL reset_reqvalid got=%b exp=0", ImemReqValid); end
    tests_run++; if (ImemReqAddr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=00000000", ImemReqAddr); end
    tests_run++; if (InstrD !== 32'h13) begin tests_failed++; $display("FAIL reset_instr got=%h exp=00000013", InstrD); end
    tests_run++; if (PCD !== 32'h0) begin tests_failed++; $display("FAIL reset_pcd got=%h exp=00000000", PCD); end
    tests_run++; if (PCPlus4D !== 32'h0) begin tests_failed++; $display("FAIL reset_pcplus4 got=%h exp=00000000", PCPlus4D); end
    tests_run++; if (ValidD !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", ValidD); end
  endtask

  task automatic test_basic();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0) begin tests_failed++; $display("FAIL first_req got=%b/%h exp=1/00000000", ImemReqValid, ImemReqAddr); end
    drive(0, 1, 1, 32'h00500093, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b0 || ImemReqAddr !== 32'h4 || ImemReqValid !== 1'b1) begin tests_failed++; $display("FAIL cycle2 got=%b/%h/%b exp=0/00000004/1", ValidD, ImemReqAddr, ImemReqValid); end
    drive(0, 1, 1, 32'h00600113, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b1 || InstrD !== 32'h00500093) begin tests_failed++; $display("FAIL first_instr got=%b/%h exp=1/00500093", ValidD, InstrD); end
    tests_run++; if (PCD !== 32'h0 || PCPlus4D !== 32'h4 || ImemReqAddr !== 32'h8) begin tests_failed++; $display("FAIL first_pc got=%h/%h/%h exp=0/4/8", PCD, PCPlus4D, ImemReqAddr); end
  endtask

  task automatic test_stall();
    drive(0, 1, 1, 32'h002081B3, 1, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b0) begin tests_failed++; $display("FAIL stall_noreq got=%b exp=0", ImemReqValid); end
    tests_run++; if (ValidD !== 1'b1 || InstrD !== 32'h00600113 || PCD !== 32'h4) begin tests_failed++; $display("FAIL second_instr got=%b/%h/%h exp=1/00600113/4", ValidD, InstrD, PCD); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      tests_run++; if (ImemReqValid !== 1'b0 || InstrD !== 32'h00600113 || PCD !== 32'h4 || ValidD !== 1'b1) begin tests_failed++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=0/00600113/4/1", i, ImemReqValid, InstrD, PCD, ValidD); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b0 || InstrD !== 32'h00600113) begin tests_failed++; $display("FAIL stall_release got=%b/%h exp=0/00600113", ImemReqValid, InstrD); end
  endtask

  task automatic test_ready_low();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'hC) begin tests_failed++; $display("FAIL rdylow_addr%0d got=%b/%h exp=1/0000000c", i, ImemReqValid, ImemReqAddr); end
      if (i == 0) begin
        tests_run++; if (ValidD !== 1'b1 || InstrD !== 32'h002081B3 || PCD !== 32'h8 || PCPlus4D !== 32'hC) begin tests_failed++; $display("FAIL skid_out got=%b/%h/%h/%h exp=1/002081b3/8/c", ValidD, InstrD, PCD, PCPlus4D); end
      end
      if (i == 1) begin
        tests_run++; if (ValidD !== 1'b0) begin tests_failed++; $display("FAIL skid_once got=%b exp=0", ValidD); end
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'hC) begin tests_failed++; $display("FAIL rdy_accept got=%b/%h exp=1/0000000c", ImemReqValid, ImemReqAddr); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b0) begin tests_failed++; $display("FAIL accepted_once got=%b exp=0", ImemReqValid); end
    drive(0, 0, 1, 32'h00C00193, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h10) begin tests_failed++; $display("FAIL next_after_c got=%b/%h exp=1/00000010", ImemReqValid, ImemReqAddr); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b1 || InstrD !== 32'h00C00193 || PCD !== 32'hC) begin tests_failed++; $display("FAIL instr_c got=%b/%h/%h exp=1/00c00193/c", ValidD, InstrD, PCD); end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'hA0A0A0A0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'hA1A1A1A1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h100);
    tests_run++; if (ValidD !== 1'b1 || PCD !== 32'h4 || ImemReqValid !== 1'b0) begin tests_failed++; $display("FAIL pre_redirect got=%b/%h/%b exp=1/4/0", ValidD, PCD, ImemReqValid); end
    drive(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b0 || InstrD !== 32'h13 || ImemReqValid !== 1'b0) begin tests_failed++; $display("FAIL squash got=%b/%h/%b exp=0/00000013/0", ValidD, InstrD, ImemReqValid); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin tests_failed++; $display("FAIL stale_dropped got=%b/%h exp=0/00000013", ValidD, InstrD); end
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h100) begin tests_failed++; $display("FAIL target_req got=%b/%h exp=1/00000100", ImemReqValid, ImemReqAddr); end
    drive(0, 0, 1, 32'h11111111, 0, 0, 0, 0);
    tests_run++; if (ImemReqAddr !== 32'h104) begin tests_failed++; $display("FAIL target_next got=%h exp=00000104", ImemReqAddr); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b1 || InstrD !== 32'h11111111 || PCD !== 32'h100) begin tests_failed++; $display("FAIL target_instr got=%b/%h/%h exp=1/11111111/100", ValidD, InstrD, PCD); end
  endtask

  task automatic test_redirect_issue();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h43);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h104) begin tests_failed++; $display("FAIL issue_before got=%b/%h exp=1/00000104", ImemReqValid, ImemReqAddr); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h40 || ValidD !== 1'b0) begin tests_failed++; $display("FAIL issue_redirect got=%b/%h/%b exp=1/00000040/0", ImemReqValid, ImemReqAddr, ValidD); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b0) begin tests_failed++; $display("FAIL issue_accepted got=%b exp=0", ImemReqValid); end
  endtask

  task automatic test_flush();
    drive(0, 1, 1, 32'h00A00513, 0, 0, 0, 0);
    drive(0, 1, 1, 32'h00B00593, 0, 1, 0, 0);
    tests_run++; if (ValidD !== 1'b1 || PCD !== 32'h40 || InstrD !== 32'h00A00513 || ImemReqAddr !== 32'h48) begin tests_failed++; $display("FAIL pre_flush got=%b/%h/%h/%h exp=1/40/00a00513/48", ValidD, PCD, InstrD, ImemReqAddr); end
    drive(0, 0, 1, 32'h00C00613, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin tests_failed++; $display("FAIL flush_squash got=%b/%h exp=0/00000013", ValidD, InstrD); end
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h4C) begin tests_failed++; $display("FAIL flush_pc got=%b/%h exp=1/0000004c", ImemReqValid, ImemReqAddr); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b1 || PCD !== 32'h48 || InstrD !== 32'h00C00613) begin tests_failed++; $display("FAIL post_flush got=%b/%h/%h exp=1/48/00c00613", ValidD, PCD, InstrD); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqAddr !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL wrap_req got=%h exp=fffffffc", ImemReqAddr); end
    drive(0, 0, 1, 32'h12345678, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", ImemReqValid, ImemReqAddr); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (PCD !== 32'hFFFFFFFC || PCPlus4D !== 32'h0 || InstrD !== 32'h12345678) begin tests_failed++; $display("FAIL wrap_ifid got=%h/%h/%h exp=fffffffc/0/12345678", PCD, PCPlus4D, InstrD); end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b0 || ImemReqAddr !== 32'h0 || ValidD !== 1'b0) begin tests_failed++; $display("FAIL midrst_port got=%b/%h/%b exp=0/0/0", ImemReqValid, ImemReqAddr, ValidD); end
    tests_run++; if (InstrD !== 32'h13 || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin tests_failed++; $display("FAIL midrst_ifid got=%h/%h/%h exp=00000013/0/0", InstrD, PCD, PCPlus4D); end
    drive(0, 0, 1, 32'hBAD0BAD0, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0) begin tests_failed++; $display("FAIL midrst_first got=%b/%h exp=1/00000000", ImemReqValid, ImemReqAddr); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin tests_failed++; $display("FAIL midrst_stale got=%b/%h exp=0/00000013", ValidD, InstrD); end
    drive(0, 0, 1, 32'h00700693, 0, 0, 0, 0);
    tests_run++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h4) begin tests_failed++; $display("FAIL midrst_next got=%b/%h exp=1/00000004", ImemReqValid, ImemReqAddr); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (ValidD !== 1'b1 || InstrD !== 32'h00700693 || PCD !== 32'h0) begin tests_failed++; $display("FAIL midrst_instr got=%b/%h/%h exp=1/00700693/0", ValidD, InstrD, PCD); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ready_low();
    test_redirect();
    test_redirect_issue();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
